// File: rtl/wb_write_queue_if.sv
// Writeback queue bus: producer-side handshake plus the registered regfile write port.
interface wb_write_queue_if;
    localparam int unsigned RW = 5;
    localparam int unsigned DW = 32;

    logic          in_valid;
    logic          in_ready;
    logic [RW-1:0] in_addr;
    logic [DW-1:0] in_data;
    logic          reg_write_enable;
    logic [RW-1:0] reg_write_addr;
    logic [DW-1:0] reg_write_data;

    // Queue side: accepts results, drives the regfile write port.
    modport slave (
        input  in_valid, in_addr, in_data,
        output in_ready, reg_write_enable, reg_write_addr, reg_write_data
    );

    // Producer / observer side.
    modport master (
        output in_valid, in_addr, in_data,
        input  in_ready, reg_write_enable, reg_write_addr, reg_write_data
    );
endinterface

// File: rtl/wb_write_queue.sv
// Writeback FIFO feeding the regfile write port one entry per cycle, with
// pending lookup and youngest-value forwarding for decode RAW resolution.
module wb_write_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    wb_write_queue_if.slave       wq,
    input  logic                  flush,
    input  logic                  drain_hold,
    input  logic [4:0]            q_addr1,
    input  logic [4:0]            q_addr2,
    output logic                  q_hit1,
    output logic                  q_hit2,
    output logic [31:0]           q_data1,
    output logic [31:0]           q_data2,
    output logic [AW:0]           count
);
    localparam int unsigned RW = 5;
    localparam int unsigned DW = 32;

    logic [RW-1:0] fifo_addr_q [DEPTH];
    logic [DW-1:0] fifo_data_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;
    logic          we_q,     we_d;
    logic [RW-1:0] waddr_q,  waddr_d;
    logic [DW-1:0] wdata_q,  wdata_d;

    logic          push;
    logic          pop;
    logic [AW-1:0] look_idx;

    // No full-bypass: readiness depends only on occupancy before the edge.
    assign wq.in_ready = (count_q < (AW+1)'(DEPTH));

    // x0 writes complete the handshake but are never stored; flush wins over both.
    assign push = wq.in_valid && wq.in_ready && (wq.in_addr != '0) && !flush;
    assign pop  = (count_q != '0) && !drain_hold && !flush;

    assign wq.reg_write_enable = we_q;
    assign wq.reg_write_addr   = waddr_q;
    assign wq.reg_write_data   = wdata_q;
    assign count               = count_q;

    // Next-state for pointers, occupancy and the output stage.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        we_d     = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
                we_d     = 1'b1;
                waddr_d  = fifo_addr_q[rd_ptr_q];
                wdata_d  = fifo_data_q[rd_ptr_q];
            end
            count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // Control and output-stage registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
        end
    end

    // Entry storage; validity is implied by rd_ptr/count so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= wq.in_addr;
            fifo_data_q[wr_ptr_q] <= wq.in_data;
        end
    end

    // Lookup scans oldest to youngest so the youngest match overrides.
    always_comb begin
        q_hit1   = 1'b0;
        q_data1  = '0;
        q_hit2   = 1'b0;
        q_data2  = '0;
        look_idx = '0;
        if (we_q) begin
            if (waddr_q == q_addr1) begin
                q_hit1  = 1'b1;
                q_data1 = wdata_q;
            end
            if (waddr_q == q_addr2) begin
                q_hit2  = 1'b1;
                q_data2 = wdata_q;
            end
        end
        for (int unsigned i = 0; i < DEPTH; i++) begin
            look_idx = rd_ptr_q + AW'(i);
            if ((AW+1)'(i) < count_q) begin
                if (fifo_addr_q[look_idx] == q_addr1) begin
                    q_hit1  = 1'b1;
                    q_data1 = fifo_data_q[look_idx];
                end
                if (fifo_addr_q[look_idx] == q_addr2) begin
                    q_hit2  = 1'b1;
                    q_data2 = fifo_data_q[look_idx];
                end
            end
        end
        if (q_addr1 == '0) begin
            q_hit1  = 1'b0;
            q_data1 = '0;
        end
        if (q_addr2 == '0) begin
            q_hit2  = 1'b0;
            q_data2 = '0;
        end
    end
endmodule

// File: tb/tb_wb_write_queue.sv
// Scoreboard bench for wb_write_queue: accepted writes are queued as expected
// regfile writes and a negedge monitor compares every issued write in order.
module tb_wb_write_queue;
    logic        clk = 1'b0;
    logic        rstn;
    logic        flush;
    logic        drain_hold;
    logic [4:0]  q_addr1, q_addr2;
    logic        q_hit1, q_hit2;
    logic [31:0] q_data1, q_data2;
    logic [2:0]  count;

    wb_write_queue_if wif ();

    wb_write_queue #(.DEPTH(4), .AW(2)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .wq         (wif),
        .flush      (flush),
        .drain_hold (drain_hold),
        .q_addr1    (q_addr1),
        .q_addr2    (q_addr2),
        .q_hit1     (q_hit1),
        .q_hit2     (q_hit2),
        .q_data1    (q_data1),
        .q_data2    (q_data2),
        .count      (count)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          model_cnt = 0;
    logic [36:0] exp_q [$];
    logic [36:0] mon_e;
    logic [31:0] rf [32];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every issued regfile write must match the oldest expected write.
    always @(negedge clk) begin
        if (rstn === 1'b1 && wif.reg_write_enable === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %0d data %h expected no write",
                         wif.reg_write_addr, wif.reg_write_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 32'(wif.reg_write_addr), 32'(mon_e[36:32]));
                check("wr_data", wif.reg_write_data, mon_e[31:0]);
            end
            rf[wif.reg_write_addr] = wif.reg_write_data;
        end
    end

    // One clock of stimulus; the occupancy model decides acceptance and pops.
    task automatic cycle(input logic v, input logic [4:0] a, input logic [31:0] d,
                         input logic hold, input logic fl);
        logic acc;
        logic pp;
        wif.in_valid = v;
        wif.in_addr  = a;
        wif.in_data  = d;
        drain_hold   = hold;
        flush        = fl;
        @(negedge clk);
        check("in_ready", 32'(wif.in_ready), 32'(model_cnt < 4));
        check("count", 32'(count), 32'(model_cnt));
        @(posedge clk);
        if (fl) begin
            model_cnt = 0;
            exp_q.delete();
        end else begin
            acc = v && (model_cnt < 4) && (a != 5'd0);
            pp  = (model_cnt > 0) && !hold;
            if (acc) exp_q.push_back({a, d});
            model_cnt = model_cnt + int'(acc) - int'(pp);
        end
        #1;
    endtask

    task automatic idle(input logic hold);
        cycle(1'b0, 5'd0, 32'd0, hold, 1'b0);
    endtask

    logic [31:0] valid_pat;
    logic [31:0] hold_pat;
    int          n_acc;

    initial begin
        rstn = 1'b0;
        flush = 1'b0;
        drain_hold = 1'b0;
        q_addr1 = 5'd0;
        q_addr2 = 5'd0;
        wif.in_valid = 1'b0;
        wif.in_addr = 5'd0;
        wif.in_data = 32'd0;
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        #1;
        check("rst_we", 32'(wif.reg_write_enable), 32'd0);
        check("rst_addr", 32'(wif.reg_write_addr), 32'd0);
        check("rst_data", wif.reg_write_data, 32'd0);
        check("rst_count", 32'(count), 32'd0);
        @(posedge clk);
        #2 rstn = 1'b1;
        @(posedge clk);
        #1;

        // Single write: issued exactly one cycle after acceptance.
        cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0);
        check("t1_we_accept", 32'(wif.reg_write_enable), 32'd0);
        check("t1_count", 32'(count), 32'd1);
        idle(1'b0);
        check("t1_we", 32'(wif.reg_write_enable), 32'd1);
        check("t1_addr", 32'(wif.reg_write_addr), 32'd5);
        check("t1_data", wif.reg_write_data, 32'hDEADBEEF);
        idle(1'b0);
        check("t1_we_off", 32'(wif.reg_write_enable), 32'd0);
        check("t1_rf5", rf[5], 32'hDEADBEEF);

        // Fill under hold, stall the fifth, then drain back to back.
        for (int k = 1; k <= 4; k++) cycle(1'b1, 5'(k), 32'h100 + 32'(k), 1'b1, 1'b0);
        check("t2_count_full", 32'(count), 32'd4);
        check("t2_ready_full", 32'(wif.in_ready), 32'd0);
        cycle(1'b1, 5'd6, 32'h555, 1'b1, 1'b0);
        check("t2_count_stall", 32'(count), 32'd4);
        for (int k = 1; k <= 4; k++) begin
            idle(1'b0);
            check("t2_we", 32'(wif.reg_write_enable), 32'd1);
            check("t2_addr", 32'(wif.reg_write_addr), 32'(k));
        end
        idle(1'b0);
        check("t2_we_off", 32'(wif.reg_write_enable), 32'd0);

        // Forwarding: youngest FIFO entry beats older entry and output stage.
        cycle(1'b1, 5'd7, 32'h11, 1'b1, 1'b0);
        cycle(1'b1, 5'd7, 32'h22, 1'b1, 1'b0);
        q_addr1 = 5'd7;
        q_addr2 = 5'd8;
        #1;
        check("t3_hit1", 32'(q_hit1), 32'd1);
        check("t3_data1", q_data1, 32'h22);
        check("t3_hit2", 32'(q_hit2), 32'd0);
        check("t3_data2", q_data2, 32'd0);
        idle(1'b0);
        check("t3_data1_stage_old", q_data1, 32'h22);
        idle(1'b0);
        check("t3_hit1_stage", 32'(q_hit1), 32'd1);
        check("t3_data1_stage", q_data1, 32'h22);
        idle(1'b0);
        check("t3_hit1_gone", 32'(q_hit1), 32'd0);

        // x0 write: handshake only; x0 lookup never hits.
        cycle(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b0);
        check("t4_count", 32'(count), 32'd0);
        cycle(1'b1, 5'd3, 32'h33, 1'b1, 1'b0);
        q_addr1 = 5'd0;
        q_addr2 = 5'd3;
        #1;
        check("t4_hit1", 32'(q_hit1), 32'd0);
        check("t4_data1", q_data1, 32'd0);
        check("t4_hit2", 32'(q_hit2), 32'd1);
        check("t4_data2", q_data2, 32'h33);
        for (int k = 0; k < 3; k++) idle(1'b0);

        // Wrap + concurrent enqueue/pop under a fixed toggling pattern.
        valid_pat = 32'b1011_1110_1101_1111_0111_1011_1111_1101;
        hold_pat  = 32'b0000_1111_1100_0011_1111_0000_0111_1110;
        n_acc = 0;
        for (int c = 0; c < 200 && n_acc < 10; c++) begin
            logic v;
            v = valid_pat[c % 32];
            if (v && model_cnt < 4) begin
                cycle(1'b1, 5'(11 + n_acc), 32'hA000_0000 + 32'(n_acc), hold_pat[c % 32], 1'b0);
                n_acc++;
            end else begin
                cycle(v, 5'(11 + n_acc), 32'hA000_0000 + 32'(n_acc), hold_pat[c % 32], 1'b0);
            end
            if (count > 3'd4) check("t5_count_le4", 32'(count), 32'd4);
        end
        check("t5_accepted", 32'(n_acc), 32'd10);
        for (int c = 0; c < 20 && model_cnt > 0; c++) idle(1'b0);
        idle(1'b0);
        idle(1'b0);
        check("t5_drained", 32'(exp_q.size()), 32'd0);

        // Flush with three queued: all dropped, in_valid ignored.
        for (int k = 0; k < 3; k++) cycle(1'b1, 5'(20 + k), 32'hF0 + 32'(k), 1'b1, 1'b0);
        cycle(1'b1, 5'd25, 32'hBAD, 1'b0, 1'b1);
        check("t6_flush_count", 32'(count), 32'd0);
        check("t6_flush_we", 32'(wif.reg_write_enable), 32'd0);
        for (int k = 0; k < 3; k++) idle(1'b0);

        // Flush while a write is presented: that write still completes.
        for (int k = 0; k < 3; k++) cycle(1'b1, 5'(26 + k), 32'hE0 + 32'(k), 1'b1, 1'b0);
        idle(1'b0);
        check("t6_presented_we", 32'(wif.reg_write_enable), 32'd1);
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
        check("t6_flush2_count", 32'(count), 32'd0);
        check("t6_rf26", rf[26], 32'hE0);
        for (int k = 0; k < 3; k++) idle(1'b0);
        check("t6_rf27", rf[27], 32'd0);

        // Asynchronous reset mid-drain.
        for (int k = 0; k < 3; k++) cycle(1'b1, 5'(29 + k), 32'hC0 + 32'(k), 1'b1, 1'b0);
        idle(1'b0);
        #2 rstn = 1'b0;
        #1;
        check("t6_rst_we", 32'(wif.reg_write_enable), 32'd0);
        check("t6_rst_addr", 32'(wif.reg_write_addr), 32'd0);
        check("t6_rst_data", wif.reg_write_data, 32'd0);
        check("t6_rst_count", 32'(count), 32'd0);
        exp_q.delete();
        model_cnt = 0;
        @(posedge clk);
        #3 rstn = 1'b1;
        @(posedge clk);
        #1;
        cycle(1'b1, 5'd9, 32'h99, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b0);
        check("t6_rf9", rf[9], 32'h99);
        check("end_scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
